// File: rtl/sd_pkg.sv
// Shared definitions for the SD clock generator: FSM state type and default
// half-period divisors.
package sd_pkg;

  typedef enum logic [1:0] {
    SD_STOP = 2'd0,
    SD_LOW  = 2'd1,
    SD_HIGH = 2'd2
  } sd_state_e;

  localparam int SD_SLOW_HALF = 128;
  localparam int SD_FAST_HALF = 2;

  function automatic int sd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_half_counter.sv
// Half-period counter for the SD clock generator: counts iclk cycles within
// one level of oclk_sd and flags the last cycle of that level.
module clk_half_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] half_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count: this is the last iclk cycle of the current level.
  assign tc_o = (cnt_q == (half_i - CNT_W'(1)));

endmodule

// File: rtl/sd_clk_gen.sv
// SD bus clock generator: slow/fast half-period divider with glitch-free mode
// switching, park-low stop, and registered rise/fall strobes in the iclk domain.
module sd_clk_gen
  import sd_pkg::*;
#(
  parameter int SLOW_HALF = SD_SLOW_HALF,
  parameter int FAST_HALF = SD_FAST_HALF
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic       isel_clk,
  input  logic       ienable,
  output logic       oclk_sd,
  output logic       ostb_rise,
  output logic       ostb_fall,
  output logic       ofast,
  output logic       oactive,
  output logic [1:0] ostate
);

  localparam int CNT_W = $clog2(sd_max(SLOW_HALF, FAST_HALF) + 1);

  if (SLOW_HALF < 1 || FAST_HALF < 1) begin : g_bad_half
    $error("sd_clk_gen: SLOW_HALF and FAST_HALF must both be >= 1");
  end

  sd_state_e        state_q, state_d;
  logic             sel_q, sel_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_tc;
  logic [CNT_W-1:0] half;

  // sel_q only changes on LOW entry, so both halves of a period share one H.
  assign half = sel_q ? CNT_W'(FAST_HALF) : CNT_W'(SLOW_HALF);

  clk_half_counter #(
    .CNT_W (CNT_W)
  ) u_half_cnt (
    .clk_i  (iclk),
    .rst_i  (irst),
    .clr_i  (cnt_clr),
    .inc_i  (cnt_inc),
    .half_i (half),
    .tc_o   (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    clk_d   = clk_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state_q)
      SD_STOP: begin
        cnt_clr = 1'b1;
        if (ienable) begin
          state_d = SD_LOW;
          sel_d   = isel_clk;
        end
      end
      SD_LOW: begin
        // Stop beats the rise boundary: the clock is already low.
        if (!ienable) begin
          state_d = SD_STOP;
          cnt_clr = 1'b1;
        end else if (cnt_tc) begin
          state_d = SD_HIGH;
          cnt_clr = 1'b1;
          clk_d   = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      SD_HIGH: begin
        if (cnt_tc) begin
          clk_d   = 1'b0;
          fall_d  = 1'b1;
          cnt_clr = 1'b1;
          if (ienable) begin
            state_d = SD_LOW;
            sel_d   = isel_clk;
          end else begin
            state_d = SD_STOP;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
      default: begin
        state_d = SD_STOP;
        cnt_clr = 1'b1;
        clk_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q <= SD_STOP;
      sel_q   <= 1'b0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign oclk_sd   = clk_q;
  assign ostb_rise = rise_q;
  assign ostb_fall = fall_q;
  assign ofast     = sel_q;
  assign oactive   = (state_q != SD_STOP);
  assign ostate    = state_q;

endmodule

// File: tb/tb_sd_clk_gen.sv
// Bench for sd_clk_gen: two instances (H=4/2 and H=3/1) under directed and
// random enable/select stimulus, checked every cycle against a level-timing model.
module tb_sd_clk_gen;
  import sd_pkg::*;

  logic iclk;
  logic irst;
  logic isel_clk;
  logic ienable;

  logic       a_clk, a_rise, a_fall, a_fast, a_active;
  logic       b_clk, b_rise, b_fall, b_fast, b_active;
  logic [1:0] a_state, b_state;

  int n_checks = 0;
  int n_fail   = 0;

  sd_clk_gen #(.SLOW_HALF(4), .FAST_HALF(2)) dut_a (
    .iclk(iclk), .irst(irst), .isel_clk(isel_clk), .ienable(ienable),
    .oclk_sd(a_clk), .ostb_rise(a_rise), .ostb_fall(a_fall),
    .ofast(a_fast), .oactive(a_active), .ostate(a_state)
  );

  sd_clk_gen #(.SLOW_HALF(3), .FAST_HALF(1)) dut_b (
    .iclk(iclk), .irst(irst), .isel_clk(isel_clk), .ienable(ienable),
    .oclk_sd(b_clk), .ostb_rise(b_rise), .ostb_fall(b_fall),
    .ofast(b_fast), .oactive(b_active), .ostate(b_state)
  );

  // clock/reset block
  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // {clk, rise, fall, fast, active} per instance
  logic [4:0] dut_o [2];
  logic [1:0] dut_st [2];
  assign dut_o[0]  = {a_clk, a_rise, a_fall, a_fast, a_active};
  assign dut_o[1]  = {b_clk, b_rise, b_fall, b_fast, b_active};
  assign dut_st[0] = a_state;
  assign dut_st[1] = b_state;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks how many iclk cycles the current level has lasted
  // and flips the level once it has lasted H cycles.
  int   slow_h [2] = '{4, 3};
  int   fast_h [2] = '{2, 1};
  bit   m_run  [2];
  bit   m_high [2];
  int   m_len  [2];
  bit   m_fast [2];
  bit   m_rise [2];
  bit   m_fall [2];

  always @(posedge iclk or posedge irst) begin
    for (int i = 0; i < 2; i++) begin
      if (irst) begin
        m_run[i] = 0; m_high[i] = 0; m_len[i] = 0;
        m_fast[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
      end else begin
        int h;
        h = m_fast[i] ? fast_h[i] : slow_h[i];
        m_rise[i] = 0;
        m_fall[i] = 0;
        if (!m_run[i]) begin
          if (ienable) begin
            m_run[i] = 1; m_high[i] = 0; m_len[i] = 1; m_fast[i] = isel_clk;
          end
        end else if (!m_high[i]) begin
          if (!ienable) m_run[i] = 0;
          else if (m_len[i] == h) begin
            m_high[i] = 1; m_len[i] = 1; m_rise[i] = 1;
          end else m_len[i]++;
        end else begin
          if (m_len[i] == h) begin
            m_high[i] = 0; m_fall[i] = 1;
            if (!ienable) m_run[i] = 0;
            else begin
              m_len[i] = 1; m_fast[i] = isel_clk;
            end
          end else m_len[i]++;
        end
      end
    end
  end

  // scoreboard: one expected vector per instance, compared every cycle
  logic [4:0] exp_q [$];

  always @(negedge iclk) begin
    exp_q.delete();
    for (int i = 0; i < 2; i++)
      exp_q.push_back({m_high[i], m_rise[i], m_fall[i], m_fast[i], m_run[i]});
    for (int i = 0; i < 2; i++) begin
      logic [4:0] e;
      e = exp_q.pop_front();
      check($sformatf("model_out[%0d]", i), {3'b0, dut_o[i]}, {3'b0, e});
      check($sformatf("model_stop[%0d]", i), {7'b0, (dut_st[i] == SD_STOP)}, {7'b0, !e[0]});
      check($sformatf("strobe_excl[%0d]", i), {7'b0, dut_o[i][3] & dut_o[i][2]}, 8'h0);
    end
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge iclk);
  endtask

  task automatic set_in(input logic en, input logic sel);
    #1;
    ienable  = en;
    isel_clk = sel;
  endtask

  task automatic chk_a(input string name, input logic [4:0] exp);
    check({"a_", name}, {3'b0, dut_o[0]}, {3'b0, exp});
  endtask

  task automatic chk_b(input string name, input logic [4:0] exp);
    check({"b_", name}, {3'b0, dut_o[1]}, {3'b0, exp});
  endtask

  initial begin
    irst = 1'b1; ienable = 1'b0; isel_clk = 1'b0;
    ticks(3);
    chk_a("reset", 5'b00000);
    chk_b("reset", 5'b00000);
    #1 irst = 1'b0;
    ticks(2);
    chk_a("idle", 5'b00000);

    // slow start, H=4: rise on entry edge + 4
    set_in(1, 0);
    ticks(1); chk_a("start_entry", 5'b00001);
    ticks(3); chk_a("start_low", 5'b00001);
    ticks(1); chk_a("first_rise", 5'b11001);
    ticks(1); chk_a("high_hold", 5'b10001);
    // raise select mid-high: this high phase still lasts 4
    set_in(1, 1);
    ticks(3); chk_a("switch_fall", 5'b00111);
    ticks(2); chk_a("fast_rise", 5'b11011);
    set_in(1, 0);
    ticks(2); chk_a("back_slow_fall", 5'b00101);
    ticks(4); chk_a("slow_rise", 5'b11001);
    // stop requested in high-phase cycle 1
    ticks(1); set_in(0, 0);
    ticks(2); chk_a("stop_high_hold", 5'b10001);
    ticks(1); chk_a("stop_high_fall", 5'b00100);
    ticks(3); chk_a("stopped", 5'b00000);

    // stop from LOW
    set_in(1, 0);
    ticks(1); chk_a("low_entry", 5'b00001);
    ticks(1); set_in(0, 0);
    ticks(1); chk_a("stop_low", 5'b00000);
    ticks(4); chk_a("stop_low_quiet", 5'b00000);

    // stop coinciding with the rise boundary
    set_in(1, 0);
    ticks(4); chk_a("pre_boundary", 5'b00001);
    set_in(0, 0);
    ticks(1); chk_a("stop_wins", 5'b00000);
    ticks(4);

    // H=1 on instance b
    set_in(1, 1);
    ticks(1); chk_b("h1_entry", 5'b00011);
    ticks(1); chk_b("h1_rise", 5'b11011);
    ticks(1); chk_b("h1_fall", 5'b00111);
    ticks(1); chk_b("h1_rise2", 5'b11011);

    // async reset while a's clock is high, no clock edge inside the pulse
    begin
      bit seen;
      seen = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
        ticks(1);
        if (dut_o[0][4]) seen = 1;
      end
      check("wait_a_high", {7'b0, seen}, 8'h1);
    end
    #2 irst = 1'b1;
    #1 chk_a("async_rst", 5'b00000);
    chk_b("async_rst", 5'b00000);
    isel_clk = 1'b0;
    #1 irst = 1'b0;
    ticks(1); chk_a("rst_entry", 5'b00001);
    ticks(3); chk_a("rst_low", 5'b00001);
    ticks(1); chk_a("rst_rise", 5'b11001);

    // random enable/select with occasional reset pulses
    for (int c = 0; c < 600; c++) begin
      set_in(($urandom_range(0, 11) != 0), ($urandom_range(0, 3) == 0) ? ~isel_clk : isel_clk);
      if ($urandom_range(0, 149) == 0) begin
        #1 irst = 1'b1;
        #1 irst = 1'b0;
      end
      ticks(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
